// File: rtl/mips_pkg.sv
// Shared encodings and instruction-field helpers for the single-cycle MIPS core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // imm16 and target26 overlap the R-type fields, so they are split out side by side.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.opcode   = instr[31:26];
    f.rs       = instr[25:21];
    f.rt       = instr[20:16];
    f.rd       = instr[15:11];
    f.shamt    = instr[10:6];
    f.funct    = instr[5:0];
    f.imm16    = instr[15:0];
    f.target26 = instr[25:0];
    return f;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 GPR file: two combinational reads, one synchronous write, $0 tied to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] v0
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0))
      regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: 32'd0};
    else       regs_q <= regs_d;
  end

  // $0 is never written, but forcing the read keeps it zero regardless.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];
  assign v0     = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-subset core with separate instruction and data buses.
module mips_cpu_harvard_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0]   pc_q, pc_d;
  logic          active_q, active_d;
  instr_fields_t f;
  logic [31:0]   rs_val, rt_val, imm_s, imm_z;
  logic [31:0]   pc_next, wr_data, mem_addr, mem_wdata;
  logic [4:0]    wr_addr;
  logic          wr_en, mem_rd, mem_wr, rf_we, en;

  assign f     = decode_fields(instr_readdata);
  assign imm_s = {{16{f.imm16[15]}}, f.imm16};
  assign imm_z = {16'd0, f.imm16};
  // Only an explicit 0 stalls; an undriven enable runs the core.
  assign en    = !(clk_enable === 1'b0);

  mips_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr1 (f.rs),
    .raddr2 (f.rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val),
    .v0     (register_v0)
  );

  // Decode and execute.
  always_comb begin
    pc_next   = pc_q + 32'd4;
    wr_en     = 1'b0;
    wr_addr   = f.rt;
    wr_data   = 32'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (f.opcode)
      OP_RTYPE: begin
        wr_addr = f.rd;
        wr_en   = 1'b1;
        case (f.funct)
          FN_ADDU: wr_data = rs_val + rt_val;
          FN_SUBU: wr_data = rs_val - rt_val;
          FN_AND:  wr_data = rs_val & rt_val;
          FN_OR:   wr_data = rs_val | rt_val;
          FN_XOR:  wr_data = rs_val ^ rt_val;
          FN_SLT:  wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: wr_data = {31'd0, rs_val < rt_val};
          FN_SLL:  wr_data = rt_val << f.shamt;
          FN_SRL:  wr_data = rt_val >> f.shamt;
          FN_SRA:  wr_data = $unsigned($signed(rt_val) >>> f.shamt);
          FN_JR: begin
            wr_en   = 1'b0;
            pc_next = rs_val;
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (f.rt == RT_BGEZ && !rs_val[31]) pc_next = pc_q + imm_s;
        if (f.rt == RT_BLTZ &&  rs_val[31]) pc_next = pc_q + imm_s;
      end
      OP_J:     pc_next = {pc_q[31:28], f.target26, 2'b00};
      OP_BEQ:   if (rs_val == rt_val) pc_next = pc_q + imm_s;
      OP_BNE:   if (rs_val != rt_val) pc_next = pc_q + imm_s;
      OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + imm_s; end
      OP_SLTI:  begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
      OP_SLTIU: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < imm_s}; end
      OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & imm_z; end
      OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | imm_z; end
      OP_XORI:  begin wr_en = 1'b1; wr_data = rs_val ^ imm_z; end
      OP_LUI:   begin wr_en = 1'b1; wr_data = {f.imm16, 16'd0}; end
      OP_LW: begin
        mem_rd   = 1'b1;
        mem_addr = rs_val + imm_s;
        wr_en    = 1'b1;
        wr_data  = data_readdata;
      end
      OP_SW: begin
        mem_wr    = 1'b1;
        mem_addr  = rs_val + imm_s;
        mem_wdata = rt_val;
      end
      default: ;
    endcase
  end

  // Commit: a next PC of zero halts instead of retiring the instruction.
  always_comb begin
    pc_d     = pc_q;
    active_d = active_q;
    rf_we    = 1'b0;
    if (active_q && en) begin
      if (pc_next == 32'd0) begin
        active_d = 1'b0;
      end else begin
        pc_d  = pc_next;
        rf_we = wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      active_q <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      active_q <= active_d;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc_q;
  assign data_address   = mem_addr;
  assign data_read      = mem_rd && active_q;
  assign data_write     = mem_wr && active_q && en;
  assign data_writedata = mem_wdata;

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed plus randomized bench against an architectural model of the core.
module tb_mips_cpu_harvard_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic [31:0] instr_readdata = 32'd0;
  logic [31:0] data_readdata = 32'd0;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, data_address, data_writedata;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_active;

  mips_cpu_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    logic [31:0] w;
    w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [31:0] w;
    w = {op, 5'(rs), 5'(rt), imm};
    return w;
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'hBFC0_0000;
    m_active = 1'b1;
  endtask

  task automatic do_reset();
    instr_readdata = 32'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("reset_pc", instr_address, 32'hBFC0_0000);
    chk("reset_active", {31'd0, active}, 32'd1);
    chk("reset_v0", register_v0, 32'd0);
    chk("reset_dwrite", {31'd0, data_write}, 32'd0);
    chk("reset_dread", {31'd0, data_read}, 32'd0);
  endtask

  // Present one instruction, check bus outputs, clock it, then check architectural state.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdat, input logic en);
    logic [5:0]  op, fn;
    logic [31:0] a, b, npc, wval, ea, ewd;
    logic [15:0] imm;
    int          dst;
    logic        erd, ewr;
    op = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
    a = m_regs[ins[25:21]]; b = m_regs[ins[20:16]];
    npc = m_pc + 4; dst = 0; wval = 0; ea = 0; ewd = 0; erd = 0; ewr = 0;
    if (op == 6'h00) begin
      dst = int'(ins[15:11]);
      case (fn)
        6'h21: wval = a + b;
        6'h23: wval = a - b;
        6'h24: wval = a & b;
        6'h25: wval = a | b;
        6'h26: wval = a ^ b;
        6'h2a: wval = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h2b: wval = (a < b) ? 1 : 0;
        6'h00: wval = b << ins[10:6];
        6'h02: wval = b >> ins[10:6];
        6'h03: wval = $signed(b) >>> ins[10:6];
        6'h08: begin npc = a; dst = 0; end
        default: dst = 0;
      endcase
    end else begin
      dst = int'(ins[20:16]);
      case (op)
        6'h01: begin
          dst = 0;
          if ((ins[20:16] == 1 && $signed(a) >= 0) || (ins[20:16] == 0 && $signed(a) < 0))
            npc = m_pc + sx(imm);
        end
        6'h02: begin dst = 0; npc = {m_pc[31:28], ins[25:0], 2'b00}; end
        6'h04: begin dst = 0; if (a == b) npc = m_pc + sx(imm); end
        6'h05: begin dst = 0; if (a != b) npc = m_pc + sx(imm); end
        6'h09: wval = a + sx(imm);
        6'h0a: wval = ($signed(a) < $signed(sx(imm))) ? 1 : 0;
        6'h0b: wval = (a < sx(imm)) ? 1 : 0;
        6'h0c: wval = a & {16'd0, imm};
        6'h0d: wval = a | {16'd0, imm};
        6'h0e: wval = a ^ {16'd0, imm};
        6'h0f: wval = {imm, 16'd0};
        6'h23: begin ea = a + sx(imm); erd = m_active; wval = rdat; end
        6'h2b: begin dst = 0; ea = a + sx(imm); ewr = m_active && en; ewd = b; end
        default: dst = 0;
      endcase
    end
    instr_readdata = ins;
    data_readdata  = rdat;
    clk_enable     = en;
    #1;
    chk("data_address", data_address, ea);
    chk("data_read", {31'd0, data_read}, {31'd0, erd});
    chk("data_write", {31'd0, data_write}, {31'd0, ewr});
    chk("data_writedata", data_writedata, ewd);
    @(posedge clk); #1;
    if (en && m_active) begin
      if (npc == 32'd0) m_active = 1'b0;
      else begin
        m_pc = npc;
        if (dst != 0) m_regs[dst] = wval;
      end
    end
    chk("pc", instr_address, m_pc);
    chk("active", {31'd0, active}, {31'd0, m_active});
    chk("v0", register_v0, m_regs[2]);
    clk_enable = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd, k;
    logic [15:0] imm;
    logic [31:0] w;
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    imm = 16'($urandom);
    k = $urandom_range(0, 25);
    case (k)
      0:  w = enc_r(rs, rt, rd, 0, 6'h21);
      1:  w = enc_r(rs, rt, rd, 0, 6'h23);
      2:  w = enc_r(rs, rt, rd, 0, 6'h24);
      3:  w = enc_r(rs, rt, rd, 0, 6'h25);
      4:  w = enc_r(rs, rt, rd, 0, 6'h26);
      5:  w = enc_r(rs, rt, rd, 0, 6'h2a);
      6:  w = enc_r(rs, rt, rd, 0, 6'h2b);
      7:  w = enc_r(0, rt, rd, $urandom_range(0, 31), 6'h00);
      8:  w = enc_r(0, rt, rd, $urandom_range(0, 31), 6'h02);
      9:  w = enc_r(0, rt, rd, $urandom_range(0, 31), 6'h03);
      10: w = enc_r(rs, 0, 0, 0, 6'h08);
      11: w = enc_i(6'h09, rs, rt, imm);
      12: w = enc_i(6'h0a, rs, rt, imm);
      13: w = enc_i(6'h0b, rs, rt, imm);
      14: w = enc_i(6'h0c, rs, rt, imm);
      15: w = enc_i(6'h0d, rs, rt, imm);
      16: w = enc_i(6'h0e, rs, rt, imm);
      17: w = enc_i(6'h0f, 0, rt, imm);
      18: w = enc_i(6'h23, rs, rt, imm);
      19: w = enc_i(6'h2b, rs, rt, imm);
      20: w = enc_i(6'h04, rs, rt, imm);
      21: w = enc_i(6'h05, rs, rt, imm);
      22: w = enc_i(6'h01, rs, $urandom_range(0, 1), imm);
      23: w = {6'h02, 26'($urandom)};
      24: w = enc_i(6'h3f, rs, rt, imm);
      default: w = enc_i(6'h09, 0, rt, imm);
    endcase
    return w;
  endfunction

  initial begin
    model_reset();
    do_reset();

    // ADDIU then LW into $2
    step(enc_i(6'h09, 0, 1, 16'h0020), 32'd0, 1'b1);
    instr_readdata = enc_i(6'h23, 1, 2, 16'h0000);
    data_readdata  = 32'hF000_0000;
    #1;
    chk("lw_addr_const", data_address, 32'h0000_0020);
    chk("lw_read_const", {31'd0, data_read}, 32'd1);
    step(enc_i(6'h23, 1, 2, 16'h0000), 32'hF000_0000, 1'b1);
    chk("lw_v0_const", register_v0, 32'hF000_0000);

    // BGEZ taken on $1, taken on $0, not taken on negative $2
    chk("bgez_start_pc", instr_address, 32'hBFC0_0008);
    step(enc_i(6'h01, 1, 1, 16'h0080), 32'd0, 1'b1);
    chk("bgez_r1_pc", instr_address, 32'hBFC0_0088);
    step(enc_i(6'h01, 0, 1, 16'h0080), 32'd0, 1'b1);
    chk("bgez_r0_pc", instr_address, 32'hBFC0_0108);
    step(enc_i(6'h01, 2, 1, 16'h0080), 32'd0, 1'b1);
    chk("bgez_r2_pc", instr_address, 32'hBFC0_010C);

    // SW asserts data_write for its cycle only
    step(enc_i(6'h09, 0, 3, 16'h0007), 32'd0, 1'b1);
    instr_readdata = enc_i(6'h2b, 0, 3, 16'h0004);
    #1;
    chk("sw_write_const", {31'd0, data_write}, 32'd1);
    chk("sw_addr_const", data_address, 32'h0000_0004);
    chk("sw_data_const", data_writedata, 32'h0000_0007);
    step(enc_i(6'h2b, 0, 3, 16'h0004), 32'd0, 1'b1);
    step(32'd0, 32'd0, 1'b1);
    chk("sw_write_after", {31'd0, data_write}, 32'd0);

    // Stall for three cycles, then resume
    for (int i = 0; i < 3; i++) step(enc_i(6'h09, 0, 2, 16'h1234), 32'd0, 1'b0);
    chk("stall_v0", register_v0, 32'hF000_0000);
    step(enc_i(6'h09, 0, 2, 16'h1234), 32'd0, 1'b1);
    chk("resume_v0", register_v0, 32'h0000_1234);

    // Halt through JR $0, stay halted, recover with reset
    step(enc_r(0, 0, 0, 0, 6'h08), 32'd0, 1'b1);
    chk("halt_active", {31'd0, active}, 32'd0);
    step(enc_i(6'h09, 0, 2, 16'h5555), 32'd0, 1'b1);
    chk("halt_v0_frozen", register_v0, 32'h0000_1234);
    do_reset();

    // Randomized program with occasional stalls; reset on halt or mid-program
    for (int n = 0; n < 400; n++) begin
      step(rand_instr(), $urandom, ($urandom_range(0, 7) != 0));
      if (!m_active || $urandom_range(0, 99) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_harvard_core.md
# mips_cpu_harvard_core

Single-cycle 32-bit MIPS-subset CPU with separate instruction and data buses (Harvard). One instruction completes per enabled clock. Instruction fetch and data reads are combinational; data writes take one cycle. This is the top-level CPU block. Memories are external and sit in the testbench or SoC wrapper.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- active  output  1  high while running; low once halted.
- register_v0  output  32  live contents of GPR $2, combinational from the register file.
- clk_enable  input  1  stall control; state updates unless clk_enable === 1'b0. Undriven/X counts as enabled.
- instr_address  output  32  current PC.
- instr_readdata  input  32  instruction at instr_address, same cycle.
- data_address  output  32  rs + sign_ext(imm16) for LW/SW, else 0.
- data_write  output  1  high during SW; memory writes at the next rising edge.
- data_read  output  1  high during LW.
- data_writedata  output  32  rt value for SW, else 0.
- data_readdata  input  32  combinational read data for data_address.

## Operation
- Reset (reset=1 at a rising edge):
  - PC=RESET_VECTOR, all 32 GPRs=0, active=1.
  - Outputs after reset: instr_address=BFC00000, register_v0=0, data_write=0, data_read=0.
- Each enabled cycle: decode instr_readdata, execute, write back, update PC.
- Instruction set:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE.
  - REGIMM (opcode 000001): BGEZ (rt=00001), BLTZ (rt=00000).
  - J-type: J.
- Arithmetic and immediates:
  - Arithmetic wraps modulo 2^32; no overflow traps.
  - Logical immediates zero-extend; all others sign-extend.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Register rules: $0 reads 0 and ignores writes. Destination is rd for R-type, rt for I-type.
- LW: writes data_readdata to rt at the end of the cycle.
- Addresses are passed through unaligned; misalignment is not checked.
- Branches:
  - No delay slot.
  - Taken: next PC = PC + sign_ext(imm16), with the offset used as a byte displacement and not shifted.
  - Not taken: next PC = PC + 4.
  - BGEZ is taken when rs[31]==0; BLTZ when rs[31]==1.
- J: next PC = {PC[31:28], target26, 2'b00}.
- JR: next PC = rs.
- Halt:
  - When the next PC would be 32'h00000000, set active=0 and freeze PC and registers.
  - The CPU stays halted until reset.
- Unsupported encodings execute as NOP (PC+4, no writes).

## Timing
- Fetch-to-retire latency is one cycle. A write-back is visible on register_v0 and to the next instruction after the rising edge.
- data_* outputs are combinational from the current instruction. data_write is asserted for exactly the SW cycle.
- With clk_enable===0, PC, registers and active hold, and data_write is forced low.
- Reset has priority over clk_enable and over halt.
- Reset asserted mid-program restarts at RESET_VECTOR on the next edge.

## Structure
- Package mips_pkg: opcode, funct and REGIMM rt constants; RESET_VECTOR; instruction field typedef (rs, rt, rd, shamt, funct, imm16, target26).
- Sub-module mips_regfile: 32x32, two combinational read ports, one synchronous write port, $0 hard-wired to zero, synchronous clear on reset, v0 tap output.
- ALU, decode, next-PC logic and memory control live inline in the top level.

## Test plan
- Reset then idle: after one reset edge, instr_address=BFC00000, active=1, register_v0=0.
- ADDIU then LW:
  - Stimulus: ADDIU $1,$0,0x20, then LW $2,0($1) with data_readdata=F0000000.
  - Required: data_address=00000020, data_read=1 during LW; register_v0=F0000000 the next cycle.
- BGEZ taken/not-taken, with imm16=0x0080:
  - BGEZ $1 at BFC00008 ($1=0x20) -> BFC00088.
  - BGEZ $0 -> BFC00108.
  - BGEZ $2 ($2=F0000000) -> BFC0010C.
- SW:
  - Stimulus: ADDIU $3,$0,7; then SW $3,4($0).
  - Required: data_write=1, data_address=4, data_writedata=7 for one cycle only.
- Halt: JR to a register holding 0 -> active=0, instr_address frozen; after reset, active=1 and PC=BFC00000.
- Stall: clk_enable=0 for 3 cycles -> PC and register_v0 unchanged; execution resumes when clk_enable returns to 1.
